// File: rtl/memory_access_unit_if.sv
// Request/response and data-bus signal bundle of the memory access unit.
// master = the unit itself, slave = execute stage plus bus slave around it.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE             4'd0
`define EXCEP_MISALIGNED_LOAD  4'd4
`define EXCEP_LOAD_FAULT       4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT      4'd7
`endif

interface memory_access_unit_if;
  logic                      memAccess_In;
  logic [31:0]               memAddr_In;
  logic [31:0]               memData_In;
  logic [1:0]                memDataWidth_In;
  logic                      memIsRead_In;
  logic                      memAccessOK_Out;
  logic [31:0]               memData_Out;
  logic [`EXCEPTION_LEN-1:0] memException_Out;
  logic                      busValid_Out;
  logic [31:0]               busAddr_Out;
  logic                      busWrite_Out;
  logic [31:0]               busWData_Out;
  logic [3:0]                busWStrb_Out;
  logic                      busReady_In;
  logic [31:0]               busRData_In;
  logic                      busError_In;

  modport master (
    input  memAccess_In, memAddr_In, memData_In, memDataWidth_In, memIsRead_In,
    output memAccessOK_Out, memData_Out, memException_Out,
    output busValid_Out, busAddr_Out, busWrite_Out, busWData_Out, busWStrb_Out,
    input  busReady_In, busRData_In, busError_In
  );

  modport slave (
    output memAccess_In, memAddr_In, memData_In, memDataWidth_In, memIsRead_In,
    input  memAccessOK_Out, memData_Out, memException_Out,
    input  busValid_Out, busAddr_Out, busWrite_Out, busWData_Out, busWStrb_Out,
    output busReady_In, busRData_In, busError_In
  );
endinterface

// File: rtl/memory_access_unit.sv
// Load/store engine between execute and a single-port word bus: one bus
// transaction per request, right-aligned load data, misalignment/fault/timeout.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE             4'd0
`define EXCEP_MISALIGNED_LOAD  4'd4
`define EXCEP_LOAD_FAULT       4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT      4'd7
`endif

module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk_In,
  input logic                   resetN_In,
  memory_access_unit_if.master  mau
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                strb_q, strb_d;
  logic                      write_q, write_d;
  logic [1:0]                width_q, width_d;
  logic                      abort_q, abort_d;
  logic [31:0]               wait_q, wait_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [`EXCEPTION_LEN-1:0] exc_q, exc_d;

  logic                      req_misaligned;
  logic [3:0]                store_strb;
  logic [31:0]               store_data;
  logic [31:0]               shifted_rdata;
  logic [31:0]               load_data;
  logic                      timed_out;
  logic                      abort_now;
  logic [`EXCEPTION_LEN-1:0] fault_code;

  // Alignment check and store lane placement, taken from the raw request.
  always_comb begin
    req_misaligned = 1'b0;
    store_strb     = 4'b0000;
    store_data     = 32'd0;
    case (mau.memDataWidth_In)
      `MEM_WIDTH_BYTE: begin
        store_strb = 4'b0001 << mau.memAddr_In[1:0];
        store_data = {4{mau.memData_In[7:0]}};
      end
      `MEM_WIDTH_HALF: begin
        req_misaligned = mau.memAddr_In[0];
        store_strb     = 4'b0011 << {mau.memAddr_In[1], 1'b0};
        store_data     = {2{mau.memData_In[15:0]}};
      end
      `MEM_WIDTH_WORD: begin
        req_misaligned = (mau.memAddr_In[1:0] != 2'b00);
        store_strb     = 4'b1111;
        store_data     = mau.memData_In;
      end
      default: ;
    endcase
  end

  // Right-align the returned word on the captured byte lane, then trim to width.
  always_comb begin
    shifted_rdata = mau.busRData_In >> {addr_q[1:0], 3'b000};
    load_data     = shifted_rdata;
    case (width_q)
      `MEM_WIDTH_BYTE: load_data = {24'd0, shifted_rdata[7:0]};
      `MEM_WIDTH_HALF: load_data = {16'd0, shifted_rdata[15:0]};
      default:         load_data = shifted_rdata;
    endcase
  end

  assign timed_out  = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_LAST);
  assign abort_now  = abort_q | ~mau.memAccess_In;
  assign fault_code = write_q ? `EXCEP_STORE_FAULT : `EXCEP_LOAD_FAULT;

  // Next-state and datapath updates; an abort still lets the bus cycle finish.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    width_d = width_q;
    abort_d = abort_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (mau.memAccess_In) begin
          width_d = mau.memDataWidth_In;
          abort_d = 1'b0;
          wait_d  = 32'd0;
          rdata_d = 32'd0;
          exc_d   = `EXCEP_NONE;
          if (mau.memDataWidth_In == `MEM_WIDTH_NONE) begin
            state_d = DONE;
          end else if (req_misaligned) begin
            exc_d   = mau.memIsRead_In ? `EXCEP_MISALIGNED_LOAD : `EXCEP_MISALIGNED_STORE;
            state_d = DONE;
          end else begin
            addr_d  = mau.memAddr_In;
            write_d = ~mau.memIsRead_In;
            strb_d  = mau.memIsRead_In ? 4'b0000 : store_strb;
            wdata_d = mau.memIsRead_In ? 32'd0 : store_data;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (mau.busReady_In) begin
          rdata_d = load_data;
          exc_d   = mau.busError_In ? fault_code : `EXCEP_NONE;
          state_d = abort_now ? IDLE : DONE;
        end else if (timed_out) begin
          rdata_d = 32'd0;
          exc_d   = fault_code;
          state_d = abort_now ? IDLE : DONE;
        end else begin
          wait_d  = wait_q + 32'd1;
          abort_d = abort_now;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_In) begin
    if (!resetN_In) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'b0000;
      write_q <= 1'b0;
      width_q <= `MEM_WIDTH_NONE;
      abort_q <= 1'b0;
      wait_q  <= 32'd0;
      rdata_q <= 32'd0;
      exc_q   <= `EXCEP_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      width_q <= width_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign mau.busValid_Out     = (state_q == BUS);
  assign mau.busAddr_Out      = {addr_q[31:2], 2'b00};
  assign mau.busWrite_Out     = write_q;
  assign mau.busWData_Out     = wdata_q;
  assign mau.busWStrb_Out     = strb_q;
  assign mau.memAccessOK_Out  = (state_q == DONE);
  assign mau.memData_Out      = rdata_q;
  assign mau.memException_Out = (state_q == DONE) ? exc_q : `EXCEP_NONE;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed cases from the test plan
// plus randomized accesses scored against an arithmetic reference model.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE             4'd0
`define EXCEP_MISALIGNED_LOAD  4'd4
`define EXCEP_LOAD_FAULT       4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT      4'd7
`endif

module tb_memory_access_unit;

  localparam int T = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   errors = 0;
  int   checks = 0;

  memory_access_unit_if mau();

  memory_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk_In    (clk),
    .resetN_In (resetN),
    .mau       (mau)
  );

  always #5 clk = ~clk;

  // Observations gathered by run_access for one request.
  int          obs_first_valid, obs_valid_cnt, obs_ok_cycle, obs_ok_cnt;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_strb;
  logic        obs_write, obs_stable, obs_exc_idle_bad;
  logic [`EXCEPTION_LEN-1:0] obs_exc;

  // Drives one request as execute plus a bus slave would, and records what
  // the unit did over a fixed window long enough to cover a timeout.
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                            input logic rd, input int waits, input bit never, input bit err,
                            input logic [31:0] word, input int abort_at);
    int vidx;
    obs_first_valid = -1; obs_valid_cnt = 0; obs_ok_cycle = -1; obs_ok_cnt = 0;
    obs_stable = 1'b1; obs_exc_idle_bad = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_strb = '0; obs_write = 1'b0; obs_data = '0; obs_exc = '0;
    vidx = 0;
    @(negedge clk);
    mau.memAccess_In = 1'b1; mau.memAddr_In = a; mau.memData_In = d;
    mau.memDataWidth_In = w; mau.memIsRead_In = rd; mau.busReady_In = 1'b0;
    for (int k = 1; k <= T + 6; k++) begin
      @(negedge clk);
      if (k == abort_at) mau.memAccess_In = 1'b0;
      if (mau.busValid_Out) begin
        vidx++;
        obs_valid_cnt++;
        if (obs_first_valid < 0) begin
          obs_first_valid = k; obs_addr = mau.busAddr_Out; obs_wdata = mau.busWData_Out;
          obs_strb = mau.busWStrb_Out; obs_write = mau.busWrite_Out;
        end else if (obs_addr !== mau.busAddr_Out || obs_wdata !== mau.busWData_Out ||
                     obs_strb !== mau.busWStrb_Out || obs_write !== mau.busWrite_Out) begin
          obs_stable = 1'b0;
        end
        if (!never && vidx == waits + 1) begin
          mau.busReady_In = 1'b1; mau.busError_In = err; mau.busRData_In = word;
        end else begin
          mau.busReady_In = 1'b0; mau.busError_In = 1'($urandom_range(0, 1));
          mau.busRData_In = $urandom;
        end
      end else begin
        mau.busReady_In = 1'($urandom_range(0, 1)); mau.busError_In = 1'($urandom_range(0, 1));
        mau.busRData_In = $urandom;
      end
      if (mau.memAccessOK_Out) begin
        obs_ok_cnt++;
        if (obs_ok_cycle < 0) begin
          obs_ok_cycle = k; obs_data = mau.memData_Out; obs_exc = mau.memException_Out;
        end
        mau.memAccess_In = 1'b0;
      end else if (mau.memException_Out !== `EXCEP_NONE) begin
        obs_exc_idle_bad = 1'b1;
      end
    end
    mau.memAccess_In = 1'b0; mau.busReady_In = 1'b0; mau.busError_In = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mau.busValid_Out !== 1'b0 || mau.memAccessOK_Out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: valid=%b ok=%b required 0 0", mau.busValid_Out, mau.memAccessOK_Out);
    end
    checks++;
    if (mau.memData_Out !== 32'd0 || mau.memException_Out !== `EXCEP_NONE) begin
      errors++; $display("[TB] FAIL reset_result: data=%h exc=%0d required 0 0", mau.memData_Out, mau.memException_Out);
    end
    checks++;
    if (mau.busAddr_Out !== 32'd0 || mau.busWData_Out !== 32'd0 || mau.busWStrb_Out !== 4'd0 || mau.busWrite_Out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_bus: addr=%h wdata=%h strb=%b write=%b required all 0",
                         mau.busAddr_Out, mau.busWData_Out, mau.busWStrb_Out, mau.busWrite_Out);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    run_access(32'h100, 32'h0, `MEM_WIDTH_WORD, 1'b1, 0, 1'b0, 1'b0, 32'hDEADBEEF, 0);
    checks++;
    if (obs_first_valid !== 1 || obs_valid_cnt !== 1 || obs_addr !== 32'h100 || obs_strb !== 4'd0) begin
      errors++; $display("[TB] FAIL lw_bus: first=%0d cnt=%0d addr=%h strb=%b required 1 1 00000100 0000",
                         obs_first_valid, obs_valid_cnt, obs_addr, obs_strb);
    end
    checks++;
    if (obs_ok_cycle !== 2 || obs_data !== 32'hDEADBEEF || obs_exc !== `EXCEP_NONE) begin
      errors++; $display("[TB] FAIL lw_result: okcyc=%0d data=%h exc=%0d required 2 deadbeef 0",
                         obs_ok_cycle, obs_data, obs_exc);
    end
  endtask

  task automatic test_lanes();
    run_access(32'h103, 32'h0, `MEM_WIDTH_BYTE, 1'b1, 1, 1'b0, 1'b0, 32'h80FF_0000, 0);
    checks++;
    if (obs_data !== 32'h0000_0080 || obs_ok_cycle !== 3) begin
      errors++; $display("[TB] FAIL lb_lane3: data=%h okcyc=%0d required 00000080 3", obs_data, obs_ok_cycle);
    end
    run_access(32'h202, 32'h1234, `MEM_WIDTH_HALF, 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
    checks++;
    if (obs_addr !== 32'h200 || obs_strb !== 4'b1100 || obs_wdata !== 32'h1234_1234 || obs_write !== 1'b1) begin
      errors++; $display("[TB] FAIL sh_lane2: addr=%h strb=%b wdata=%h write=%b required 00000200 1100 12341234 1",
                         obs_addr, obs_strb, obs_wdata, obs_write);
    end
  endtask

  task automatic test_misaligned();
    run_access(32'h102, 32'h0, `MEM_WIDTH_WORD, 1'b1, 0, 1'b0, 1'b0, 32'h0, 0);
    checks++;
    if (obs_valid_cnt !== 0 || obs_ok_cycle !== 1 || obs_exc !== `EXCEP_MISALIGNED_LOAD) begin
      errors++; $display("[TB] FAIL lw_misaligned: valid=%0d okcyc=%0d exc=%0d required 0 1 4",
                         obs_valid_cnt, obs_ok_cycle, obs_exc);
    end
    run_access(32'h1, 32'h55, `MEM_WIDTH_HALF, 1'b0, 0, 1'b0, 1'b0, 32'h0, 0);
    checks++;
    if (obs_valid_cnt !== 0 || obs_ok_cycle !== 1 || obs_exc !== `EXCEP_MISALIGNED_STORE) begin
      errors++; $display("[TB] FAIL sh_misaligned: valid=%0d okcyc=%0d exc=%0d required 0 1 6",
                         obs_valid_cnt, obs_ok_cycle, obs_exc);
    end
  endtask

  task automatic test_faults();
    run_access(32'h400, 32'h0, `MEM_WIDTH_WORD, 1'b1, 0, 1'b1, 1'b0, 32'h0, 0);
    checks++;
    if (obs_valid_cnt !== T || obs_ok_cycle !== T + 1 || obs_exc !== `EXCEP_LOAD_FAULT || obs_stable !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout: valid=%0d okcyc=%0d exc=%0d stable=%b required %0d %0d 5 1",
                         obs_valid_cnt, obs_ok_cycle, obs_exc, obs_stable, T, T + 1);
    end
    run_access(32'h408, 32'hCAFE, `MEM_WIDTH_WORD, 1'b0, 2, 1'b0, 1'b1, 32'h0, 0);
    checks++;
    if (obs_ok_cycle !== 4 || obs_exc !== `EXCEP_STORE_FAULT) begin
      errors++; $display("[TB] FAIL store_error: okcyc=%0d exc=%0d required 4 7", obs_ok_cycle, obs_exc);
    end
  endtask

  task automatic test_abort();
    run_access(32'h500, 32'hA5A5_5A5A, `MEM_WIDTH_WORD, 1'b0, 3, 1'b0, 1'b0, 32'h0, 2);
    checks++;
    if (obs_valid_cnt !== 4 || obs_ok_cnt !== 0 || obs_wdata !== 32'hA5A5_5A5A) begin
      errors++; $display("[TB] FAIL abort: valid=%0d okpulses=%0d wdata=%h required 4 0 a5a55a5a",
                         obs_valid_cnt, obs_ok_cnt, obs_wdata);
    end
    checks++;
    if (mau.busValid_Out !== 1'b0 || mau.memAccessOK_Out !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_idle: valid=%b ok=%b required 0 0", mau.busValid_Out, mau.memAccessOK_Out);
    end
  endtask

  task automatic test_reset_mid_bus();
    logic [31:0] word;
    @(negedge clk);
    mau.memAccess_In = 1'b1; mau.memAddr_In = 32'h300; mau.memDataWidth_In = `MEM_WIDTH_WORD;
    mau.memIsRead_In = 1'b0; mau.memData_In = 32'h7777_7777; mau.busReady_In = 1'b0;
    @(negedge clk);
    checks++;
    if (mau.busValid_Out !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_start: valid=%b required 1", mau.busValid_Out);
    end
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    checks++;
    if (mau.busValid_Out !== 1'b0 || mau.memAccessOK_Out !== 1'b0 || mau.busAddr_Out !== 32'd0 ||
        mau.busWStrb_Out !== 4'd0 || mau.busWrite_Out !== 1'b0 || mau.busWData_Out !== 32'd0 ||
        mau.memException_Out !== `EXCEP_NONE) begin
      errors++; $display("[TB] FAIL midreset_outputs: valid=%b ok=%b addr=%h strb=%b write=%b wdata=%h exc=%0d required all 0",
                         mau.busValid_Out, mau.memAccessOK_Out, mau.busAddr_Out, mau.busWStrb_Out,
                         mau.busWrite_Out, mau.busWData_Out, mau.memException_Out);
    end
    resetN = 1'b1; mau.memAccess_In = 1'b0;
    word = $urandom;
    run_access(32'h104, 32'h0, `MEM_WIDTH_WORD, 1'b1, 0, 1'b0, 1'b0, word, 0);
    checks++;
    if (obs_ok_cycle !== 2 || obs_data !== word || obs_exc !== `EXCEP_NONE) begin
      errors++; $display("[TB] FAIL midreset_after: okcyc=%0d data=%h exc=%0d required 2 %h 0",
                         obs_ok_cycle, obs_data, obs_exc, word);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] word;
    logic [8:0]  got_ok, got_valid, exp_ok, exp_valid;
    word = $urandom;
    got_ok = '0; got_valid = '0; exp_ok = '0; exp_valid = '0;
    @(negedge clk);
    mau.memAccess_In = 1'b1; mau.memAddr_In = 32'h40; mau.memDataWidth_In = `MEM_WIDTH_WORD;
    mau.memIsRead_In = 1'b1; mau.busReady_In = 1'b1; mau.busError_In = 1'b0; mau.busRData_In = word;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      got_ok[k] = mau.memAccessOK_Out;
      got_valid[k] = mau.busValid_Out;
      exp_valid[k] = (k % 3 == 1);
      exp_ok[k] = (k % 3 == 2);
      if (mau.memAccessOK_Out) begin
        checks++;
        if (mau.memData_Out !== word) begin
          errors++; $display("[TB] FAIL b2b_data: cycle %0d data=%h required %h", k, mau.memData_Out, word);
        end
      end
      if (k == 8) mau.memAccess_In = 1'b0;
    end
    mau.busReady_In = 1'b0;
    checks++;
    if (got_ok !== exp_ok || got_valid !== exp_valid) begin
      errors++; $display("[TB] FAIL b2b_timing: ok=%b valid=%b required %b %b", got_ok, got_valid, exp_ok, exp_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, d, word, exp_wdata, exp_data, mask;
    logic [1:0]  w;
    logic        rd, mis, nobus;
    logic [3:0]  exp_strb;
    logic [`EXCEPTION_LEN-1:0] exp_exc;
    int          waits, abort_at, lane, exp_valid;
    bit          never, err;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; d = $urandom; word = $urandom;
      w = 2'($urandom_range(0, 3)); rd = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      never = ($urandom_range(0, 7) == 0);
      err = ($urandom_range(0, 5) == 0);
      lane = int'(a % 4);
      mis = (w == `MEM_WIDTH_HALF && lane % 2 == 1) || (w == `MEM_WIDTH_WORD && lane != 0);
      nobus = (w == `MEM_WIDTH_NONE) || mis;
      exp_valid = nobus ? 0 : (never ? T : waits + 1);
      abort_at = 0;
      if (!nobus && $urandom_range(0, 7) == 0) abort_at = $urandom_range(1, exp_valid);
      if (w == `MEM_WIDTH_BYTE) begin
        mask = 32'hFF; exp_strb = 4'(1 << lane); exp_wdata = (d & 32'hFF) * 32'h0101_0101;
      end else if (w == `MEM_WIDTH_HALF) begin
        mask = 32'hFFFF; exp_strb = 4'(3 << lane); exp_wdata = (d & 32'hFFFF) * 32'h0001_0001;
      end else begin
        mask = 32'hFFFF_FFFF; exp_strb = 4'hF; exp_wdata = d;
      end
      if (rd) exp_strb = 4'h0;
      exp_data = (word / (32'd1 << (8 * lane))) & mask;
      if (mis) exp_exc = rd ? `EXCEP_MISALIGNED_LOAD : `EXCEP_MISALIGNED_STORE;
      else if (!nobus && (never || err)) exp_exc = rd ? `EXCEP_LOAD_FAULT : `EXCEP_STORE_FAULT;
      else exp_exc = `EXCEP_NONE;

      run_access(a, d, w, rd, waits, never, err, word, abort_at);

      checks++;
      if (obs_valid_cnt !== exp_valid || obs_exc_idle_bad !== 1'b0) begin
        errors++; $display("[TB] FAIL rnd%0d valid_cnt: got %0d excleak=%b required %0d 0", i, obs_valid_cnt, obs_exc_idle_bad, exp_valid);
      end
      if (!nobus) begin
        checks++;
        if (obs_first_valid !== 1 || obs_addr !== (a & 32'hFFFF_FFFC) || obs_write !== !rd ||
            obs_strb !== exp_strb || obs_stable !== 1'b1 || (!rd && obs_wdata !== exp_wdata)) begin
          errors++; $display("[TB] FAIL rnd%0d bus: first=%0d addr=%h write=%b strb=%b wdata=%h stable=%b required 1 %h %b %b %h 1",
                             i, obs_first_valid, obs_addr, obs_write, obs_strb, obs_wdata, obs_stable,
                             a & 32'hFFFF_FFFC, !rd, exp_strb, exp_wdata);
        end
      end
      checks++;
      if (obs_ok_cnt !== ((abort_at > 0) ? 0 : 1)) begin
        errors++; $display("[TB] FAIL rnd%0d ok_pulses: got %0d required %0d", i, obs_ok_cnt, (abort_at > 0) ? 0 : 1);
      end
      if (abort_at == 0) begin
        checks++;
        if (obs_ok_cycle !== (nobus ? 1 : exp_valid + 1) || obs_exc !== exp_exc) begin
          errors++; $display("[TB] FAIL rnd%0d result: okcyc=%0d exc=%0d required %0d %0d",
                             i, obs_ok_cycle, obs_exc, nobus ? 1 : exp_valid + 1, exp_exc);
        end
        if (rd && !nobus && exp_exc == `EXCEP_NONE) begin
          checks++;
          if (obs_data !== exp_data) begin
            errors++; $display("[TB] FAIL rnd%0d load_data: got %h required %h", i, obs_data, exp_data);
          end
        end
      end
    end
  endtask

  initial begin
    mau.memAccess_In = 1'b0; mau.memAddr_In = '0; mau.memData_In = '0;
    mau.memDataWidth_In = `MEM_WIDTH_NONE; mau.memIsRead_In = 1'b0;
    mau.busReady_In = 1'b0; mau.busRData_In = '0; mau.busError_In = 1'b0;
    test_reset();
    test_load_word();
    test_lanes();
    test_misaligned();
    test_faults();
    test_abort();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
